// File: rtl/grf_pkg.sv
// Shared defaults for the general register file.
//   GRF_DATA_W : default register width
//   GRF_ADDR_W : default register address width
//   REG_ZERO   : address of the hardwired-zero register
package grf_pkg;
    localparam int         GRF_DATA_W = 32;
    localparam int         GRF_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO   = 5'd0;
endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a producer issues in ID
// and cleared when its result is written back in WB.
//   clk, reset       : clock, synchronous active-high reset
//   we, wa           : write-back enable/address (clears the bit)
//   sb_set, sb_addr  : producer issue (sets the bit)
//   ra               : packed read addresses, NUM_RD ports
//   rd_pend          : per-port pending flag, masked when the write-back is bypassed
//   any_pend         : OR of all registered bits
import grf_pkg::*;

module grf_scoreboard #(
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0]        rd_pend,
    output logic                     any_pend
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] sb_q;
    logic             set, clr;

    assign set = sb_set && (sb_addr != ZERO);
    assign clr = we && (wa != ZERO);

    // Clear is applied first so a same-address set from a new producer wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            if (clr) sb_q[wa]      <= 1'b0;
            if (set) sb_q[sb_addr] <= 1'b1;
        end
    end

    assign any_pend = |sb_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_pend
        logic [ADDR_W-1:0] a;
        logic              byp;
        assign a   = ra[k*ADDR_W +: ADDR_W];
        // The value being written back this cycle is forwarded, so it is no longer a hazard.
        assign byp = (BYPASS != 0) && clr && (wa == a);
        assign rd_pend[k] = (a != ZERO) && sb_q[a] && !byp;
    end
endmodule

// File: rtl/grf_mp.sv
// General register file for the pipelined MIPS core.
// NUM_RD combinational read ports, one synchronous write port, optional
// write-to-read bypass, and a pending-write scoreboard. Register 0 reads as zero.
//   clk, reset       : clock, synchronous active-high reset
//   we, wa, wd       : write port (WB stage)
//   ra, rd           : packed read addresses / data, port k at slice k
//   sb_set, sb_addr  : mark a register as having a write in flight (ID issue)
//   rd_pend          : per-port hazard flag
//   any_pend         : any register pending
import grf_pkg::*;

module grf_mp #(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [NUM_RD-1:0]        rd_pend,
    output logic                     any_pend
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    assign wr_ok = we && (wa != ZERO);

    // Register 0 is never written, so after reset it holds zero; reads of it are
    // forced to zero anyway so that the mux does not depend on that.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = ra[k*ADDR_W +: ADDR_W];
        always_comb begin
            rd[k*DATA_W +: DATA_W] = regs[a];
            if (a == ZERO)
                rd[k*DATA_W +: DATA_W] = '0;
            else if ((BYPASS != 0) && wr_ok && (wa == a))
                rd[k*DATA_W +: DATA_W] = wd;
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .ra       (ra),
        .rd_pend  (rd_pend),
        .any_pend (any_pend)
    );
endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: a 4-port bypassing instance and a 2-port non-bypassing
// instance share the same stimulus and are compared against a register/scoreboard
// model held as plain arrays.
module tb_grf_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            reset, we, sb_set;
    logic [AW-1:0]   wa, sb_addr;
    logic [DW-1:0]   wd;
    logic [4*AW-1:0] ra;
    logic [4*DW-1:0] rd_a;
    logic [3:0]      pend_a;
    logic            any_a;
    logic [2*DW-1:0] rd_b;
    logic [1:0]      pend_b;
    logic            any_b;

    int ntests = 0;
    int nfail  = 0;

    logic [DW-1:0] mreg  [DEPTH];
    bit            mpend [DEPTH];

    always #5 clk = ~clk;

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
        .sb_set(sb_set), .sb_addr(sb_addr), .rd_pend(pend_a), .any_pend(any_a)
    );

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra[2*AW-1:0]), .rd(rd_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .rd_pend(pend_b), .any_pend(any_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int k);
        return ra[k*AW +: AW];
    endfunction

    // A same-cycle write to a nonzero register is visible only with bypass.
    function automatic logic [DW-1:0] exp_rd(input int k, input bit byp);
        logic [AW-1:0] a = port_addr(k);
        if (a == 0) return '0;
        if (byp && we && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic exp_pend(input int k, input bit byp);
        logic [AW-1:0] a = port_addr(k);
        if (a == 0) return 1'b0;
        return mpend[a] && !(byp && we && wa == a);
    endfunction

    function automatic logic exp_any();
        for (int i = 0; i < DEPTH; i++) if (mpend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s rd_a[%0d]", tag, k), rd_a[k*DW +: DW], exp_rd(k, 1'b1));
            chk($sformatf("%s pend_a[%0d]", tag, k), DW'(pend_a[k]), DW'(exp_pend(k, 1'b1)));
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s rd_b[%0d]", tag, k), rd_b[k*DW +: DW], exp_rd(k, 1'b0));
            chk($sformatf("%s pend_b[%0d]", tag, k), DW'(pend_b[k]), DW'(exp_pend(k, 1'b0)));
        end
        chk({tag, " any_a"}, DW'(any_a), DW'(exp_any()));
        chk({tag, " any_b"}, DW'(any_b), DW'(exp_any()));
    endtask

    // One rising edge; the model applies the same register-file rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mreg[i]  = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                mreg[wa]  = wd;
                mpend[wa] = 1'b0;
            end
            if (sb_set && sb_addr != 0) mpend[sb_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we = 1'b0; sb_set = 1'b0;
        wa = '0; wd = '0; sb_addr = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        ra = {a3, a2, a1, a0};
        #1;
    endtask

    task automatic rand_cycle(input int amax);
        we      = 1'($urandom_range(0, 1));
        wa      = AW'($urandom_range(0, amax));
        wd      = $urandom;
        sb_set  = 1'($urandom_range(0, 1));
        sb_addr = AW'($urandom_range(0, amax));
        set_ra(AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)),
               AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mreg[i] = '0;
            mpend[i] = 1'b0;
        end
        idle();
        ra = '0;

        // Reset from power-up.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_ra(5'd1, 5'd7, 5'd20, 5'd31);
        check_all("por");

        // Random writes/sets, then reset with concurrent write and set.
        for (int n = 0; n < 20; n++) begin
            rand_cycle(31);
            check_all("pre_rst");
            tick();
        end
        reset = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'hA5A5A5A5; sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        idle();
        for (int n = 0; n < 4; n++) begin
            set_ra(AW'($urandom_range(1, 31)), AW'($urandom_range(1, 31)), 5'd4, AW'(n + 1));
            check_all("rst");
            chk("rst rd_a0 zero", rd_a[DW-1:0], 32'h0);
            chk("rst any_a zero", DW'(any_a), 32'h0);
        end

        // Bypass versus no-bypass on a same-cycle write.
        we = 1'b1; wa = 5'd5; wd = 32'h00001111;
        tick();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        set_ra(5'd5, 5'd5, 5'd0, 5'd0);
        check_all("byp");
        chk("byp rd_a0", rd_a[DW-1:0], 32'hDEADBEEF);
        chk("nobyp rd_b0 old", rd_b[DW-1:0], 32'h00001111);
        tick();
        idle();
        #1;
        chk("nobyp rd_b0 new", rd_b[DW-1:0], 32'hDEADBEEF);

        // Writes to register 0 are discarded.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        check_all("wr0 same");
        tick();
        idle();
        #1;
        check_all("wr0");
        chk("wr0 rd_a0", rd_a[DW-1:0], 32'h0);
        chk("wr0 any_a", DW'(any_a), 32'h0);

        // Scoreboard set, then bypass-masked clear.
        sb_set = 1'b1; sb_addr = 5'd8;
        tick();
        idle();
        set_ra(5'd0, 5'd8, 5'd0, 5'd0);
        check_all("sb8");
        chk("sb8 pend_a1", DW'(pend_a[1]), 32'h1);
        chk("sb8 any_a", DW'(any_a), 32'h1);
        we = 1'b1; wa = 5'd8; wd = 32'h0BADF00D;
        #1;
        check_all("sb8 wb");
        chk("sb8 wb pend_a1", DW'(pend_a[1]), 32'h0);
        chk("sb8 wb pend_b1", DW'(pend_b[1]), 32'h1);
        tick();
        idle();
        #1;
        check_all("sb8 clr");
        chk("sb8 clr any_a", DW'(any_a), 32'h0);

        // Set wins over a same-address clear; different addresses both apply.
        sb_set = 1'b1; sb_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33333333;
        tick();
        idle();
        set_ra(5'd3, 5'd4, 5'd0, 5'd0);
        check_all("sc3");
        chk("sc3 pend_a0", DW'(pend_a[0]), 32'h1);
        sb_set = 1'b1; sb_addr = 5'd4; we = 1'b1; wa = 5'd3; wd = 32'h44444444;
        tick();
        idle();
        #1;
        check_all("sc4");
        chk("sc4 pend_a0", DW'(pend_a[0]), 32'h0);
        chk("sc4 pend_a1", DW'(pend_a[1]), 32'h1);

        // All four ports on one register.
        we = 1'b1; wa = 5'd9; wd = 32'h12345678;
        tick();
        idle();
        set_ra(5'd9, 5'd9, 5'd9, 5'd9);
        check_all("quad");
        for (int k = 0; k < 4; k++)
            chk($sformatf("quad rd_a%0d", k), rd_a[k*DW +: DW], 32'h12345678);

        // Random traffic on a narrow address range to force collisions.
        for (int n = 0; n < 300; n++) begin
            rand_cycle((n % 2 == 0) ? 7 : 31);
            reset = ($urandom_range(0, 49) == 0);
            if (!reset) check_all("rnd");
            tick();
        end
        idle();
        #1;
        check_all("end");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
